// File: rtl/mem_pkg.sv
// Shared types for the core's load/store port and the memory responder behind it.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    // Wide enough for the largest legal latency (15).
    localparam int unsigned CNT_WIDTH = 4;

endpackage

// File: rtl/store_lane_aligner.sv
// Maps an access size and byte offset onto RAM byte enables and lane-replicated store data.
module store_lane_aligner
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        lane_data  = wdata;
        misaligned = 1'b0;
        case (mem_size_t'(size))
            MEM_BYTE: begin
                be        = 4'b0001 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            MEM_HALF: begin
                be         = 4'b0011 << addr_lo;
                lane_data  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            MEM_WORD: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: one load/store at a time over valid/ready handshakes,
// with the RAM access committed on the cycle the response becomes valid.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [CNT_WIDTH-1:0] LAT_M1 = CNT_WIDTH'(LATENCY - 1);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    resp_state_t          state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 lat_we;
    logic [31:0]          lat_addr;
    logic [1:0]           lat_size;
    logic [31:0]          lat_wdata;
    logic                 rsp_load;
    logic [31:0]          ram_rdata;
    logic [31:0]          mem [DEPTH];

    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [1:0]            cur_size;
    logic [31:0]           cur_wdata;
    logic [3:0]            be;
    logic [31:0]           lane_data;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  cur_err;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] word_idx;

    // With LATENCY=1 the access commits on the accept edge, before the latch holds the request.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_size  = lat_size;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_size  = req_size;
            cur_wdata = req_wdata;
        end
    end

    store_lane_aligner u_aligner (
        .size       (cur_size),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .be         (be),
        .lane_data  (lane_data),
        .misaligned (misaligned)
    );

    assign out_of_range = (cur_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign cur_err      = misaligned | (cur_size == 2'd3) | out_of_range;
    assign word_idx     = cur_addr[ADDR_WIDTH+1:2];
    assign commit       = !reset &&
                          (((state == IDLE) && req_valid && (LAT_M1 == '0)) ||
                           ((state == WAIT) && (cnt == CNT_WIDTH'(1))));

    always_ff @(posedge clk) begin
        if (commit && !cur_err) begin
            if (cur_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end else begin
                ram_rdata <= mem[word_idx];
            end
        end
    end

    assign rsp_rdata = (rsp_valid && rsp_load) ? ram_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_size  <= req_size;
                        lat_wdata <= req_wdata;
                        cnt       <= LAT_M1;
                        req_ready <= 1'b0;
                        if (LAT_M1 == '0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= cur_err;
                            rsp_load  <= !cur_we && !cur_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_WIDTH'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cur_err;
                        rsp_load  <= !cur_we && !cur_err;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_load  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
